// File: rtl/escalonador_display_if.sv
// Image-source request/response and display byte-stream signals of the frame scheduler.
// The master modport is the scheduler side; the slave modport is the image source plus display controller side.
interface escalonador_display_if;
  logic [9:0] img_addr;
  logic [4:0] img_estado;
  logic [7:0] img_data;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       disp_last;
  logic       disp_ready;
  logic       busy;

  modport master (
    output img_addr, img_estado, disp_data, disp_valid, disp_last, busy,
    input  img_data, disp_ready
  );

  modport slave (
    input  img_addr, img_estado, disp_data, disp_valid, disp_last, busy,
    output img_data, disp_ready
  );
endinterface

// File: rtl/escalonador_display.sv
// Frame scheduler: pushes 1024-byte frames to the display after reset, on estado change and on refresh,
// splicing the attribute bar graph into page 7.
module escalonador_display #(
  parameter int unsigned REFRESH_CICLOS = 2_700_000,
  parameter logic [7:0]  BAR_CHEIA      = 8'hFF,
  parameter logic [7:0]  BAR_VAZIA      = 8'h81
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           estado,
  input  logic [7:0]           fome,
  input  logic [7:0]           felicidade,
  input  logic [7:0]           sono,
  escalonador_display_if.master bus
);

  localparam int TW = $clog2(REFRESH_CICLOS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(REFRESH_CICLOS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          r_pend;
  logic [4:0]    r_estadoPrev;
  logic [9:0]    r_idx;
  logic [4:0]    r_fome;
  logic [4:0]    r_felicidade;
  logic [4:0]    r_sono;
  logic [9:0]    r_imgAddr;
  logic [4:0]    r_imgEstado;
  logic [7:0]    r_dispData;
  logic          r_dispValid;
  logic          r_dispLast;
  logic          r_busy;

  logic          w_wrap;
  logic          w_event;
  logic          w_start;
  logic [6:0]    w_col;
  logic [4:0]    w_level;
  logic [4:0]    w_off;
  logic          w_inBar;
  logic [7:0]    w_barByte;
  logic          w_unusedBits;

  // Bar length only depends on the five upper bits of each attribute.
  assign w_unusedBits = ^{fome[2:0], felicidade[2:0], sono[2:0]};

  assign w_wrap  = (r_timer == TIMER_MAX);
  assign w_event = (estado != r_estadoPrev) || w_wrap;
  assign w_start = (r_state == S_IDLE) && r_pend;

  always_comb begin
    w_col     = r_idx[6:0];
    w_level   = 5'd0;
    w_off     = 5'd0;
    w_inBar   = 1'b0;
    w_barByte = 8'h00;
    if (w_col < 7'd32) begin
      w_level = r_fome;
      w_off   = w_col[4:0];
      w_inBar = 1'b1;
    end else if (w_col >= 7'd48 && w_col < 7'd80) begin
      w_level = r_felicidade;
      w_off   = 5'(w_col - 7'd48);
      w_inBar = 1'b1;
    end else if (w_col >= 7'd96) begin
      w_level = r_sono;
      w_off   = 5'(w_col - 7'd96);
      w_inBar = 1'b1;
    end
    if (w_inBar) begin
      w_barByte = (w_off < w_level) ? BAR_CHEIA : BAR_VAZIA;
    end
  end

  // Previous estado keeps tracking during reset so release never looks like a state change.
  always_ff @(posedge clk) begin
    r_estadoPrev <= estado;
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_pend       <= 1'b1;
      r_idx        <= 10'd0;
      r_fome       <= 5'd0;
      r_felicidade <= 5'd0;
      r_sono       <= 5'd0;
      r_imgAddr    <= 10'd0;
      r_imgEstado  <= 5'd0;
      r_dispData   <= 8'h00;
      r_dispValid  <= 1'b0;
      r_dispLast   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_timer <= w_wrap ? '0 : r_timer + 1'b1;
      // A new event in the frame-start cycle must survive the clear.
      if (w_event) begin
        r_pend <= 1'b1;
      end else if (w_start) begin
        r_pend <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_imgEstado  <= estado;
            r_fome       <= fome[7:3];
            r_felicidade <= felicidade[7:3];
            r_sono       <= sono[7:3];
            r_idx        <= 10'd0;
            r_busy       <= 1'b1;
            r_state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_imgAddr <= r_idx;
          r_state   <= S_DATA;
        end
        S_DATA: begin
          r_dispData  <= (r_idx[9:7] != 3'd7) ? bus.img_data : w_barByte;
          r_dispValid <= 1'b1;
          r_dispLast  <= &r_idx;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (bus.disp_ready) begin
            r_dispValid <= 1'b0;
            r_dispLast  <= 1'b0;
            if (&r_idx) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 10'd1;
              r_state <= S_ADDR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.img_addr   = r_imgAddr;
  assign bus.img_estado = r_imgEstado;
  assign bus.disp_data  = r_dispData;
  assign bus.disp_valid = r_dispValid;
  assign bus.disp_last  = r_dispLast;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_escalonador_display.sv
// Bench for escalonador_display: frame timing, page-7 bars, event merging, backpressure, reset,
// and a second instance with a short refresh period for back-to-back refresh frames.
`timescale 1ns/1ps
module tb_escalonador_display;

  typedef struct {
    int         nBytes;
    int         nBadData;
    int         nBadLast;
    int         nUnstable;
    int         nStalls;
    logic [4:0] est;
  } frameRec_t;

  typedef struct {
    int         col;
    logic [7:0] exp;
  } barVec_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       rst2N;
  logic [4:0] estado;
  logic [4:0] estado2;
  logic [7:0] fome;
  logic [7:0] felicidade;
  logic [7:0] sono;
  logic       readyTb;
  logic       done2 = 1'b0;

  int checks = 0;
  int errors = 0;

  frameRec_t  frameQ[$];
  frameRec_t  cur = '{default: 0};
  int         byteIdx = 0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevLast = 1'b0;
  logic [7:0] frameBuf[1024];
  int         cyc1 = 0;
  int         riseQ[$];
  logic       prevBusy = 1'b0;

  escalonador_display_if bus();
  escalonador_display_if bus2();

  always #5 clk = ~clk;

  escalonador_display #(.REFRESH_CICLOS(5000)) dut (
    .clk(clk), .rst_n(rstN), .estado(estado), .fome(fome),
    .felicidade(felicidade), .sono(sono), .bus(bus)
  );

  escalonador_display #(.REFRESH_CICLOS(3100)) dut2 (
    .clk(clk), .rst_n(rst2N), .estado(estado2), .fome(fome),
    .felicidade(felicidade), .sono(sono), .bus(bus2)
  );

  function automatic logic [7:0] imgModel(logic [9:0] a, logic [4:0] e);
    return a[7:0] ^ {e, a[9:7]};
  endfunction

  function automatic logic [7:0] barModel(int col, logic [7:0] f, logic [7:0] h, logic [7:0] s);
    int lvl;
    int start;
    if (col < 32) begin
      lvl = f; start = 0;
    end else if (col >= 48 && col < 80) begin
      lvl = h; start = 48;
    end else if (col >= 96) begin
      lvl = s; start = 96;
    end else begin
      return 8'h00;
    end
    return ((col - start) < lvl / 8) ? 8'hFF : 8'h81;
  endfunction

  assign bus.img_data   = imgModel(bus.img_addr, bus.img_estado);
  assign bus.disp_ready = readyTb;
  assign bus2.img_data   = imgModel(bus2.img_addr, bus2.img_estado);
  assign bus2.disp_ready = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] e, input logic [7:0] f, input logic [7:0] h, input logic [7:0] s);
    estado     = e;
    fome       = f;
    felicidade = h;
    sono       = s;
  endtask

  // Collects every handshaked byte, its stability while stalled, and closes a record every 1024 bytes.
  task automatic monitorStep();
    logic [7:0] exp;
    if (!rstN) begin
      byteIdx   = 0;
      prevStall = 1'b0;
      prevBusy  = 1'b0;
      cur       = '{default: 0};
      return;
    end
    if (bus.busy && !prevBusy) riseQ.push_back(cyc1);
    prevBusy = bus.busy;
    if (prevStall && (!bus.disp_valid || bus.disp_data != prevData || bus.disp_last != prevLast))
      cur.nUnstable++;
    prevStall = bus.disp_valid && !bus.disp_ready;
    if (prevStall) cur.nStalls++;
    prevData = bus.disp_data;
    prevLast = bus.disp_last;
    if (bus.disp_valid && bus.disp_ready) begin
      if (byteIdx == 0) cur.est = bus.img_estado;
      if (bus.img_estado != cur.est) cur.nBadData++;
      exp = (byteIdx < 896) ? imgModel(10'(byteIdx), cur.est)
                            : barModel(byteIdx % 128, fome, felicidade, sono);
      if (bus.disp_data != exp) cur.nBadData++;
      if (bus.disp_last != (byteIdx == 1023)) cur.nBadLast++;
      frameBuf[byteIdx] = bus.disp_data;
      byteIdx++;
      cur.nBytes = byteIdx;
      if (byteIdx == 1024) begin
        frameQ.push_back(cur);
        cur     = '{default: 0};
        byteIdx = 0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitorStep();
  end

  initial forever begin
    @(posedge clk);
    cyc1 = rstN ? cyc1 + 1 : 0;
  end

  task automatic waitFrames(input int n, input int budget);
    while (frameQ.size() < n && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    checkOutput($sformatf("frames done %0d", n), frameQ.size(), n);
  endtask

  task automatic waitByte(input int nFrames, input int b, input int budget);
    while (!(frameQ.size() == nFrames && byteIdx >= b) && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    checkOutput($sformatf("reached byte %0d", b), byteIdx >= b, 1);
  endtask

  task automatic checkFrame(input int k, input logic [4:0] expEst);
    frameRec_t f;
    if (k >= frameQ.size()) begin
      checkOutput($sformatf("frame %0d present", k), frameQ.size(), k + 1);
      return;
    end
    f = frameQ[k];
    checkOutput($sformatf("frame %0d img_estado", k), f.est, expEst);
    checkOutput($sformatf("frame %0d bad bytes", k), f.nBadData, 0);
    checkOutput($sformatf("frame %0d bad disp_last", k), f.nBadLast, 0);
    checkOutput($sformatf("frame %0d unstable while stalled", k), f.nUnstable, 0);
  endtask

  task automatic checkRise(input int k, input int expCyc);
    checkOutput($sformatf("busy rise %0d cycle", k), (riseQ.size() > k) ? riseQ[k] : -1, expCyc);
  endtask

  initial begin : mainSeq
    barVec_t barTab[13];
    int      firstHs;
    int      budget;

    barTab = '{'{0, 8'hFF}, '{7, 8'hFF}, '{8, 8'h81}, '{31, 8'h81}, '{32, 8'h00},
               '{47, 8'h00}, '{48, 8'h81}, '{79, 8'h81}, '{80, 8'h00}, '{95, 8'h00},
               '{96, 8'hFF}, '{126, 8'hFF}, '{127, 8'h81}};

    applyStimulus(5'd3, 8'h40, 8'h00, 8'hFF);
    rstN    = 1'b0;
    readyTb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst img_addr",   bus.img_addr, 0);
    checkOutput("rst img_estado", bus.img_estado, 0);
    checkOutput("rst disp_data",  bus.disp_data, 0);
    checkOutput("rst disp_valid", bus.disp_valid, 0);
    checkOutput("rst disp_last",  bus.disp_last, 0);
    checkOutput("rst busy",       bus.busy, 0);
    @(posedge clk); #1 rstN = 1'b1;

    // The display sees byte 0 on the 4th edge after release.
    firstHs = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); @(negedge clk);
      if (e == 1) checkOutput("busy after first edge", bus.busy, 1);
      if (bus.disp_valid && firstHs == 0) firstHs = e + 1;
    end
    checkOutput("first handshake edge", firstHs, 4);

    waitFrames(1, 4000);
    @(negedge clk);
    checkOutput("busy low after last byte", bus.busy, 0);
    checkFrame(0, 5'd3);
    for (int i = 0; i < 13; i++)
      checkOutput($sformatf("bar col %0d", barTab[i].col), frameBuf[896 + barTab[i].col], barTab[i].exp);

    waitByte(1, 200, 6000);
    applyStimulus(5'd7, 8'h40, 8'h00, 8'hFF);
    waitFrames(2, 4000);
    waitByte(2, 300, 4000);
    applyStimulus(5'd5, 8'h40, 8'h00, 8'hFF);
    waitFrames(4, 8000);
    checkFrame(1, 5'd3);
    checkFrame(2, 5'd7);
    checkFrame(3, 5'd5);
    checkRise(0, 1);
    checkRise(1, 5001);
    checkRise(2, 8074);
    checkRise(3, 11147);

    budget = 12000;
    while (frameQ.size() < 5 && budget > 0) begin
      @(posedge clk); #1 readyTb = 1'($urandom_range(0, 1));
      budget--;
    end
    readyTb = 1'b1;
    checkOutput("random-ready frame done", frameQ.size(), 5);
    checkRise(4, 15001);
    checkFrame(4, 5'd5);
    if (frameQ.size() >= 5) checkOutput("stalls seen", frameQ[4].nStalls > 0, 1);

    waitByte(5, 500, 10000);
    rstN = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("reset mid-frame disp_valid", bus.disp_valid, 0);
    checkOutput("reset mid-frame busy", bus.busy, 0);
    checkOutput("reset mid-frame img_addr", bus.img_addr, 0);
    riseQ.delete();
    @(posedge clk); #1 rstN = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("restart img_addr", bus.img_addr, 0);
    waitFrames(6, 4000);
    checkFrame(5, 5'd5);
    checkRise(0, 1);

    wait (done2 == 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Short refresh period: frames come from timer wraps; a wrap landing on a frame start keeps pend set.
  initial begin : refreshSeq
    int   cyc;
    int   rises[$];
    int   expRise[4];
    logic prevB;
    cyc     = 0;
    prevB   = 1'b0;
    expRise = '{1, 3101, 6200, 9273};
    estado2 = 5'd2;
    rst2N   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst2N = 1'b1;
    while (cyc < 9400) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 6198) estado2 = 5'd4;
      @(negedge clk);
      if (bus2.busy && !prevB) rises.push_back(cyc);
      prevB = bus2.busy;
    end
    checkOutput("refresh frame count", rises.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("refresh rise %0d cycle", i), (rises.size() > i) ? rises[i] : -1, expRise[i]);
    done2 = 1'b1;
  end

endmodule
